// File: rtl/cpu_run_ctrl.sv
// Run controller for the BF cpu core: loads the program, zeroes the tape,
// then gates the core with reset and clock-enable until it halts.
module cpu_run_ctrl #(
    parameter int PROG_ADDR_W = 10,
    parameter int DATA_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             load_data,
    input  logic                   load_valid,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic                   start,
    input  logic                   step,
    input  logic                   pause,
    input  logic                   abort,
    input  logic                   cpu_halt,
    output logic                   prog_we,
    output logic [PROG_ADDR_W-1:0] prog_addr,
    output logic [7:0]             prog_wdata,
    output logic                   data_we,
    output logic [DATA_ADDR_W-1:0] data_addr,
    output logic [7:0]             data_wdata,
    output logic                   cpu_rst,
    output logic                   cpu_en,
    output logic [2:0]             state,
    output logic                   done,
    output logic                   err_overflow,
    output logic [PROG_ADDR_W-1:0] prog_len,
    output logic [31:0]            run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_TERM   = 3'd2,
        S_CLEAR  = 3'd3,
        S_READY  = 3'd4,
        S_RUN    = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    // Last byte count that still leaves room for the terminator.
    localparam logic [PROG_ADDR_W-1:0] LEN_MAX =
        PROG_ADDR_W'((2 ** PROG_ADDR_W) - 2);

    state_t                 cur;
    state_t                 nxt;
    logic                   accept;
    logic                   prog_we_n;
    logic [PROG_ADDR_W-1:0] prog_addr_n;
    logic [7:0]             prog_wdata_n;
    logic                   data_we_n;
    logic [DATA_ADDR_W-1:0] data_addr_n;
    logic [PROG_ADDR_W-1:0] len_n;
    logic                   ovf_n;
    logic                   en_n;
    logic [31:0]            cycles_n;

    assign accept     = load_valid & load_ready;
    assign state      = cur;
    assign data_wdata = 8'h00;

    always_comb begin
        nxt          = cur;
        prog_we_n    = 1'b0;
        prog_addr_n  = prog_addr;
        prog_wdata_n = prog_wdata;
        data_we_n    = 1'b0;
        data_addr_n  = data_addr;
        len_n        = prog_len;
        ovf_n        = err_overflow;
        en_n         = 1'b0;
        cycles_n     = run_cycles;
        if (cpu_en && run_cycles != 32'hFFFF_FFFF)
            cycles_n = run_cycles + 32'd1;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE: if (accept) begin
                    prog_we_n    = 1'b1;
                    prog_addr_n  = '0;
                    prog_wdata_n = load_data;
                    len_n        = PROG_ADDR_W'(1);
                    ovf_n        = 1'b0;
                    nxt          = load_last ? S_TERM : S_LOAD;
                end
                S_LOAD: if (accept) begin
                    prog_we_n    = 1'b1;
                    prog_addr_n  = prog_len;
                    prog_wdata_n = load_data;
                    len_n        = prog_len + 1'b1;
                    if (load_last) begin
                        nxt = S_TERM;
                    end else if (prog_len == LEN_MAX) begin
                        ovf_n = 1'b1;
                        nxt   = S_TERM;
                    end
                end
                S_TERM: begin
                    prog_we_n    = 1'b1;
                    prog_addr_n  = prog_len;
                    prog_wdata_n = 8'h00;
                    data_we_n    = 1'b1;
                    data_addr_n  = '0;
                    cycles_n     = '0;
                    nxt          = S_CLEAR;
                end
                // data_we stays high exactly while in CLEAR, one address per cycle.
                S_CLEAR: if (&data_addr) begin
                    data_addr_n = '0;
                    nxt         = S_READY;
                end else begin
                    data_we_n   = 1'b1;
                    data_addr_n = data_addr + 1'b1;
                end
                S_READY: if (start) begin
                    en_n = 1'b1;
                    nxt  = S_RUN;
                end else if (step) begin
                    en_n = 1'b1;
                    nxt  = S_PAUSE;
                end
                S_RUN: if (cpu_halt) begin
                    nxt = S_HALTED;
                end else if (pause) begin
                    nxt = S_PAUSE;
                end else begin
                    en_n = 1'b1;
                end
                S_PAUSE: if (cpu_en && cpu_halt) begin
                    nxt = S_HALTED;
                end else if (start) begin
                    en_n = 1'b1;
                    nxt  = S_RUN;
                end else if (step) begin
                    en_n = 1'b1;
                end
                S_HALTED: if (start) begin
                    data_we_n   = 1'b1;
                    data_addr_n = '0;
                    cycles_n    = '0;
                    nxt         = S_CLEAR;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= S_IDLE;
            load_ready   <= 1'b1;
            prog_we      <= 1'b0;
            prog_addr    <= '0;
            prog_wdata   <= '0;
            data_we      <= 1'b0;
            data_addr    <= '0;
            cpu_rst      <= 1'b1;
            cpu_en       <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            prog_len     <= '0;
            run_cycles   <= '0;
        end else begin
            cur          <= nxt;
            load_ready   <= (nxt == S_IDLE) || (nxt == S_LOAD);
            prog_we      <= prog_we_n;
            prog_addr    <= prog_addr_n;
            prog_wdata   <= prog_wdata_n;
            data_we      <= data_we_n;
            data_addr    <= data_addr_n;
            cpu_rst      <= (nxt <= S_READY);
            cpu_en       <= en_n;
            done         <= (nxt == S_HALTED);
            err_overflow <= ovf_n;
            prog_len     <= len_n;
            run_cycles   <= cycles_n;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: randomized programs, run lengths
// and step gaps checked against expectations built from the run rules.
module tb_cpu_run_ctrl;

    localparam int PW = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    load_data = 8'h00;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;
    logic          start = 1'b0;
    logic          step = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          load_ready;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [7:0]    prog_wdata;
    logic          data_we;
    logic [DW-1:0] data_addr;
    logic [7:0]    data_wdata;
    logic          cpu_rst;
    logic          cpu_en;
    logic [2:0]    state;
    logic          done;
    logic          err_overflow;
    logic [PW-1:0] prog_len;
    logic [31:0]   run_cycles;

    int checks = 0;
    int errors = 0;
    logic [10:0] wq[$];
    int clr_cnt = 0;
    int clr_err = 0;
    int en_cnt = 0;
    int en_run = 0;
    int en_max = 0;
    logic [7:0] prog [0:15];
    longint rc;

    cpu_run_ctrl #(.PROG_ADDR_W(PW), .DATA_ADDR_W(DW)) dut (
        .clk(clk), .rst(rst),
        .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(load_ready),
        .start(start), .step(step), .pause(pause), .abort(abort),
        .cpu_halt(cpu_halt),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state(state), .done(done),
        .err_overflow(err_overflow), .prog_len(prog_len),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst) begin
        if (prog_we) wq.push_back({prog_addr, prog_wdata});
        if (data_we) begin
            if (data_addr != DW'(clr_cnt) || data_wdata != 8'h00) clr_err++;
            clr_cnt++;
        end
        if (cpu_en) begin
            en_cnt++;
            en_run++;
            if (en_run > en_max) en_max = en_run;
        end else begin
            en_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              input string tag);
        int n;
        n = 0;
        sample;
        while (state != s && n < budget) begin
            sample;
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic send(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = last && (i == n - 1);
            tick;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic load_chk(input int n, input bit last, input int stored,
                            input bit ovf);
        logic [10:0] e;
        wq.delete();
        clr_cnt = 0;
        clr_err = 0;
        send(n, last);
        wait_state(3'd4, 60, "load_ready_state");
        chk("wr_count", wq.size(), stored + 1);
        for (int i = 0; i < wq.size() && i <= stored; i++) begin
            e = (i < stored) ? {3'(i), prog[i]} : {3'(stored), 8'h00};
            chk($sformatf("wr%0d", i), wq[i], e);
        end
        chk("prog_len", prog_len, stored);
        chk("err_ovf", err_overflow, ovf);
        chk("clr_cnt", clr_cnt, 16);
        chk("clr_addr", clr_err, 0);
        chk("ready_rst", cpu_rst, 1);
        chk("ready_lr", load_ready, 0);
    endtask

    task automatic run_halt(input int n);
        en_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        sample;
        chk("run_state", state, 3'd5);
        chk("run_rst", cpu_rst, 0);
        chk("run_en", cpu_en, 1);
        repeat (n) tick;
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0;
        sample;
        chk("halt_state", state, 3'd7);
        chk("halt_done", done, 1);
        chk("halt_en", cpu_en, 0);
        chk("halt_cycles", run_cycles, n + 1);
        chk("halt_en_cnt", en_cnt, n + 1);
    endtask

    task automatic rerun;
        clr_cnt = 0;
        clr_err = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        sample;
        chk("rerun_state", state, 3'd3);
        chk("rerun_done", done, 0);
        chk("rerun_cycles", run_cycles, 0);
        chk("rerun_rst", cpu_rst, 1);
        wait_state(3'd4, 40, "rerun_ready");
        chk("rerun_clr", clr_cnt, 16);
        chk("rerun_addr", clr_err, 0);
    endtask

    initial begin
        int m;
        repeat (2) @(posedge clk);
        sample;
        chk("rst_state", state, 0);
        chk("rst_lr", load_ready, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_en", cpu_en, 0);
        chk("rst_we", {prog_we, data_we}, 0);
        chk("rst_addr", {prog_addr, data_addr}, 0);
        chk("rst_wdata", prog_wdata, 0);
        chk("rst_misc", {done, err_overflow, prog_len}, 0);
        chk("rst_cycles", run_cycles, 0);
        rst = 1'b0;
        tick;

        prog[0] = 8'h2B;
        prog[1] = 8'h2B;
        prog[2] = 8'h2E;
        load_chk(3, 1'b1, 3, 1'b0);

        run_halt(10);
        rerun;
        for (int r = 0; r < 3; r++) begin
            run_halt($urandom_range(1, 30));
            rerun;
        end

        en_cnt = 0;
        en_max = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick;
            step = 1'b0;
            repeat ($urandom_range(1, 4)) tick;
        end
        sample;
        chk("step_cnt", en_cnt, 3);
        chk("step_single", en_max, 1);
        chk("step_state", state, 3'd6);
        chk("step_cycles", run_cycles, 3);
        rc = 3;
        m = $urandom_range(2, 12);
        start = 1'b1;
        tick;
        start = 1'b0;
        sample;
        chk("resume_state", state, 3'd5);
        chk("resume_en", cpu_en, 1);
        repeat (m) tick;
        pause = 1'b1;
        tick;
        pause = 1'b0;
        sample;
        rc += m + 1;
        chk("pause_state", state, 3'd6);
        chk("pause_en", cpu_en, 0);
        chk("pause_cycles", run_cycles, rc);
        {start, pause, step} = 3'b111;
        tick;
        {start, pause, step} = 3'b000;
        sample;
        chk("prio_start", state, 3'd5);
        {pause, step} = 2'b11;
        tick;
        {pause, step} = 2'b00;
        sample;
        rc += 1;
        chk("prio_pause", state, 3'd6);
        chk("prio_pause_en", cpu_en, 0);
        step = 1'b1;
        tick;
        step = 1'b0;
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0;
        sample;
        chk("step_halt", state, 3'd7);
        chk("step_halt_cyc", run_cycles, rc + 1);

        start = 1'b1;
        tick;
        start = 1'b0;
        m = 0;
        sample;
        while (data_addr != DW'(5) && m < 20) begin
            sample;
            m++;
        end
        chk("clr_addr5", data_addr, 5);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        sample;
        chk("abort_state", state, 0);
        chk("abort_dwe", data_we, 0);
        chk("abort_en", cpu_en, 0);
        chk("abort_rst", cpu_rst, 1);
        chk("abort_len", prog_len, 3);

        for (int i = 0; i < 10; i++) prog[i] = 8'($urandom);
        load_chk(10, 1'b0, 7, 1'b1);

        for (int r = 0; r < 3; r++) begin
            abort = 1'b1;
            tick;
            abort = 1'b0;
            m = $urandom_range(1, 7);
            for (int i = 0; i < m; i++) prog[i] = 8'($urandom);
            load_chk(m, 1'b1, m, 1'b0);
        end

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        {start, step} = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_en", cpu_en, 0);
        chk("arst_rst", cpu_rst, 1);
        chk("arst_lr", load_ready, 1);
        chk("arst_cycles", run_cycles, 0);
        chk("arst_misc", {done, prog_len, prog_we, data_we}, 0);
        repeat (3) tick;
        chk("arst_hold", state, 0);
        {start, step} = 2'b00;
        rst = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run controller for the BF `cpu` core; sequences the core through its full run.
- Steps: accept a program byte stream, write it into instruction RAM with a 0x00 terminator, then zero the data (tape) RAM.
- After loading it holds the core in reset, then gates its execution via clock-enable: free-run, pause, single-step.
- Detects halt and counts executed cycles.

Parameters:
PROG_ADDR_W, 10, instruction RAM address width; depth PDEPTH = 2**PROG_ADDR_W
DATA_ADDR_W, 15, data RAM address width; depth DDEPTH = 2**DATA_ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
load_data  in  8  program byte
load_valid  in  1  byte valid
load_last  in  1  final byte of program, qualified by load_valid
load_ready  out  1  controller accepts byte when load_valid & load_ready
start  in  1  pulse: run / resume / rerun
step  in  1  pulse: execute one cpu cycle
pause  in  1  pulse: suspend free-run
abort  in  1  pulse: return to IDLE
cpu_halt  in  1  core reached terminator
prog_we / prog_addr[PROG_ADDR_W] / prog_wdata[8]  out  instruction RAM write port
data_we / data_addr[DATA_ADDR_W] / data_wdata[8]  out  data RAM write port; data_wdata is always 0
cpu_rst  out  1  holds core in reset
cpu_en  out  1  core clock enable
state  out  3  current state encoding
done  out  1  HALTED
err_overflow  out  1  program truncated
prog_len  out  PROG_ADDR_W  bytes stored, excluding terminator
run_cycles  out  32  cycles with cpu_en=1

Behaviour:
- States and encoding: IDLE=0, LOAD=1, TERM=2, CLEAR=3, READY=4, RUN=5, PAUSE=6, HALTED=7.
- Reset values: state=IDLE, load_ready=1, cpu_rst=1, cpu_en=0, all we=0, all addr=0, prog_wdata=0, done=0, err_overflow=0, prog_len=0, run_cycles=0.
- All outputs are registered.
- Write strobes appear the cycle after the handshake (latency 1).
- load_ready=1 only in IDLE and LOAD.
- cpu_rst=1 in IDLE, LOAD, TERM, CLEAR and READY; cpu_rst=0 otherwise.
- IDLE:
  - An accepted byte is written at addr 0, prog_len becomes 1, err_overflow is cleared.
  - Next state is LOAD, or TERM if load_last is set.
- LOAD:
  - Each accepted byte is written at addr prog_len, then prog_len increments.
  - load_last moves to TERM.
  - If the accepted byte makes prog_len=PDEPTH-1 without load_last: err_overflow=1, treat as last, go to TERM.
- TERM: one cycle; writes 0x00 at addr prog_len, then go to CLEAR.
- CLEAR:
  - data_we=1 for exactly DDEPTH consecutive cycles, data_addr 0..DDEPTH-1, then go to READY.
  - run_cycles is cleared on entry.
- READY:
  - start moves to RUN.
  - step executes one cycle with cpu_en=1, then goes to PAUSE.
- RUN:
  - cpu_en=1 every cycle.
  - pause moves to PAUSE; cpu_en=0 from the next cycle.
  - cpu_halt moves to HALTED; cpu_en drops the cycle after halt is sampled.
- PAUSE:
  - cpu_en=0.
  - start moves to RUN.
  - step gives exactly one cpu_en=1 cycle, then stays in PAUSE.
- Halt during step: cpu_halt sampled during a step cycle moves to HALTED.
- HALTED:
  - done=1, cpu_en=0.
  - start goes to CLEAR, i.e. rerun the same program on a zeroed tape; done clears.
  - A new load requires abort first.
- run_cycles: +1 each cycle cpu_en=1, saturates at 0xFFFFFFFF.
- Priority among simultaneous pulses: abort > cpu_halt > start > pause > step.
- abort from any state: next cycle IDLE, all we=0, cpu_en=0, cpu_rst=1. prog_len and err_overflow are retained until the next byte is accepted.
- Asynchronous rst mid-operation (including mid-CLEAR) returns immediately to the reset values; a partial clear is not resumed.
- load_valid outside IDLE/LOAD is ignored.
- load_last without load_valid is ignored.

Test Plan:
- Load test: DATA_ADDR_W=4. Stream bytes "+", "+", "." (3 bytes, last on third).
  - Response: prog writes (0,0x2B), (1,0x2B), (2,0x2E), (3,0x00); prog_len=3.
  - Then 16 data_we cycles at addr 0..15; state=READY.
- Run to halt: from READY, start; hold cpu_halt low for 10 cycles, then pulse it.
  - Response: cpu_rst falls, cpu_en high for exactly 10 cycles (+ halt cycle) → run_cycles=11, done=1, state=7.
- Step: from READY, step ×3 with idle gaps.
  - Response: exactly three single-cycle cpu_en pulses, state=PAUSE, run_cycles=3.
  - Then start, pause gives RUN, then PAUSE with cpu_en low next cycle.
- Overflow: PROG_ADDR_W=3. Stream 10 bytes, none marked last.
  - Response: 7 bytes stored, err_overflow=1, terminator at addr 7, load_ready=0 afterwards, bytes 8-10 ignored.
- Abort and rerun:
  - Abort mid-CLEAR (addr 5) gives IDLE next cycle with data_we=0.
  - Separately, start in HALTED re-clears the tape: run_cycles=0, done=0, then READY.
- Reset priority: assert rst asynchronously mid-RUN with start and step high.
  - Response: outputs reach reset values without a clock edge; state stays IDLE while rst is held.
